imem_load_arbiter: RTL and testbench

Owns the 256x8 instruction memory feeding the 8-bit processor and shares its single access port among three requesters: a byte-serial program loader, the processor fetch (PC -> INST), and a debug read port. It sequences the processor through idle, program-load and run phases. It stalls the processor with HOLD whenever the fetch slot is taken by another requester.

---
 rtl/imem_load_arbiter.sv | 168 ++++++++++++++++
 tb/tb_imem_load_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: 256x8 instruction memory with a single access port shared
// between a byte-serial loader, the processor fetch path and a debug read port.
// Sequences the processor through IDLE, LOAD and RUN and stalls it with HOLD
// whenever the fetch slot is given to another requester.
module imem_load_arbiter #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned DBG_WAIT = 4
) (
    input  logic       CLK,
    input  logic       CLB,
    input  logic [7:0] PC,
    output logic [7:0] INST,
    output logic       HOLD,
    input  logic       GO,
    input  logic       LD_START,
    input  logic [7:0] LD_LEN,
    input  logic       LD_VALID,
    input  logic [7:0] LD_DATA,
    output logic       LD_READY,
    output logic       LD_DONE,
    input  logic       DBG_REQ,
    input  logic [7:0] DBG_ADDR,
    output logic       DBG_ACK,
    output logic [7:0] DBG_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(DBG_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] len_q, len_d;
    logic [3:0] wait_q, wait_d;
    logic       ld_done_q, ld_done_d;
    logic       dbg_ack_q, dbg_ack_d;
    logic [7:0] dbg_data_q, dbg_data_d;

    logic [7:0] mem [DEPTH];
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic       dbg_pend;
    logic       dbg_slot;
    logic       dbg_grant;

    // A request still high during its own ACK cycle is the old request, not a new one.
    always_comb begin
        dbg_pend = DBG_REQ && !dbg_ack_q;
        dbg_slot = (state_q == ST_RUN) && dbg_pend && (wait_q == WAIT_LAST);
    end

    // Single-port address mux: loader in LOAD, debug in IDLE or a debug slot, else fetch.
    always_comb begin
        mem_addr = PC;
        if (state_q == ST_LOAD) begin
            mem_addr = cnt_q;
        end else if ((state_q == ST_IDLE) || dbg_slot) begin
            mem_addr = DBG_ADDR;
        end
        mem_rdata = mem[mem_addr];
    end

    // Next-state, load sequencing and debug arbitration.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        wait_d     = wait_q;
        ld_done_d  = 1'b0;
        dbg_ack_d  = 1'b0;
        dbg_data_d = dbg_data_q;
        mem_we     = 1'b0;
        dbg_grant  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (LD_START) begin
                    state_d = ST_LOAD;
                    len_d   = LD_LEN;
                    cnt_d   = '0;
                end else if (GO) begin
                    state_d = ST_RUN;
                end else if (dbg_pend) begin
                    dbg_grant = 1'b1;
                end
            end
            ST_LOAD: begin
                wait_d = '0;
                if (LD_VALID) begin
                    mem_we = 1'b1;
                    if (cnt_q == len_q) begin
                        state_d   = ST_RUN;
                        ld_done_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (LD_START) begin
                    state_d = ST_LOAD;
                    len_d   = LD_LEN;
                    cnt_d   = '0;
                    wait_d  = '0;
                end else if (dbg_slot) begin
                    dbg_grant = 1'b1;
                    wait_d    = '0;
                end else if (dbg_pend) begin
                    wait_d = wait_q + 4'd1;
                end else begin
                    wait_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (dbg_grant) begin
            dbg_ack_d  = 1'b1;
            dbg_data_d = mem_rdata;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (CLB) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            wait_q     <= '0;
            ld_done_q  <= 1'b0;
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            wait_q     <= wait_d;
            ld_done_q  <= ld_done_d;
            dbg_ack_q  <= dbg_ack_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    // Memory array is not reset; a reset edge suppresses any pending loader write.
    always_ff @(posedge CLK) begin
        if (mem_we && !CLB) begin
            mem[mem_addr] <= LD_DATA;
        end
    end

    // Fetch is combinational and blanked whenever the processor is stalled.
    always_comb begin
        HOLD     = !((state_q == ST_RUN) && !dbg_slot);
        INST     = HOLD ? 8'h00 : mem_rdata;
        LD_READY = (state_q == ST_LOAD);
        LD_DONE  = ld_done_q;
        DBG_ACK  = dbg_ack_q;
        DBG_DATA = dbg_data_q;
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter: randomized load data, gaps, PCs and
// debug addresses checked against a byte-array memory model and timing rules.
module tb_imem_load_arbiter;

    localparam int unsigned DBG_WAIT = 4;

    logic       CLK = 1'b0;
    logic       CLB;
    logic [7:0] PC;
    logic [7:0] INST;
    logic       HOLD;
    logic       GO;
    logic       LD_START;
    logic [7:0] LD_LEN;
    logic       LD_VALID;
    logic [7:0] LD_DATA;
    logic       LD_READY;
    logic       LD_DONE;
    logic       DBG_REQ;
    logic [7:0] DBG_ADDR;
    logic       DBG_ACK;
    logic [7:0] DBG_DATA;

    int unsigned vec = 0;
    int unsigned err = 0;
    logic [7:0]  mmem [256];

    imem_load_arbiter #(.DEPTH(256), .DBG_WAIT(DBG_WAIT)) dut (
        .CLK(CLK), .CLB(CLB), .PC(PC), .INST(INST), .HOLD(HOLD), .GO(GO),
        .LD_START(LD_START), .LD_LEN(LD_LEN), .LD_VALID(LD_VALID),
        .LD_DATA(LD_DATA), .LD_READY(LD_READY), .LD_DONE(LD_DONE),
        .DBG_REQ(DBG_REQ), .DBG_ADDR(DBG_ADDR), .DBG_ACK(DBG_ACK),
        .DBG_DATA(DBG_DATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic go_idle;
        CLB = 1'b1;
        step();
        CLB = 1'b0;
    endtask

    task automatic test_reset;
        CLB = 1'b1; GO = 1'b0; LD_START = 1'b0; LD_LEN = '0; LD_VALID = 1'b0;
        LD_DATA = '0; DBG_REQ = 1'b0; DBG_ADDR = '0; PC = '0;
        step(); step();
        vec++; if (HOLD !== 1'b1) begin err++; $display("FAIL reset_hold got %b exp 1", HOLD); end
        vec++; if (INST !== 8'h00) begin err++; $display("FAIL reset_inst got %h exp 00", INST); end
        vec++; if (LD_READY !== 1'b0) begin err++; $display("FAIL reset_ld_ready got %b exp 0", LD_READY); end
        vec++; if (LD_DONE !== 1'b0) begin err++; $display("FAIL reset_ld_done got %b exp 0", LD_DONE); end
        vec++; if (DBG_ACK !== 1'b0) begin err++; $display("FAIL reset_dbg_ack got %b exp 0", DBG_ACK); end
        vec++; if (DBG_DATA !== 8'h00) begin err++; $display("FAIL reset_dbg_data got %h exp 00", DBG_DATA); end
        CLB = 1'b0; GO = 1'b1;
        step();
        GO = 1'b0;
        vec++; if (HOLD !== 1'b0) begin err++; $display("FAIL go_hold got %b exp 0", HOLD); end
    endtask

    task automatic test_full_load;
        logic [7:0] p;
        go_idle();
        LD_LEN = 8'hFF; LD_START = 1'b1;
        step();
        LD_START = 1'b0;
        vec++; if (LD_READY !== 1'b1) begin err++; $display("FAIL full_ready got %b exp 1", LD_READY); end
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                LD_VALID = 1'b0;
                step();
                vec++; if (LD_READY !== 1'b1 || LD_DONE !== 1'b0) begin
                    err++; $display("FAIL full_gap ready=%b done=%b exp 1/0", LD_READY, LD_DONE); end
            end
            LD_VALID = 1'b1; LD_DATA = 8'(i); mmem[i] = 8'(i);
            step();
            LD_VALID = 1'b0;
            vec++; if (LD_DONE !== (i == 255)) begin
                err++; $display("FAIL full_done byte=%0d got %b exp %b", i, LD_DONE, (i == 255)); end
        end
        vec++; if (HOLD !== 1'b0) begin err++; $display("FAIL full_run_hold got %b exp 0", HOLD); end
        step();
        vec++; if (LD_DONE !== 1'b0) begin err++; $display("FAIL full_done_drop got %b exp 0", LD_DONE); end
        for (int k = 0; k < 8; k++) begin
            p = (k == 0) ? 8'hFF : (k == 1) ? 8'h00 : 8'($urandom_range(0, 255));
            PC = p;
            #1;
            vec++; if (INST !== mmem[p]) begin err++; $display("FAIL full_fetch pc=%h got %h exp %h", p, INST, mmem[p]); end
            step();
        end
    endtask

    task automatic test_load_small;
        logic [7:0] b [4];
        int unsigned gap_at;
        logic [7:0] p;
        b[0] = 8'hA1; b[1] = 8'hB2; b[2] = 8'hC3; b[3] = 8'hD4;
        gap_at = $urandom_range(0, 2);
        go_idle();
        LD_LEN = 8'h03; LD_START = 1'b1;
        step();
        LD_START = 1'b0;
        vec++; if (LD_READY !== 1'b1 || HOLD !== 1'b1) begin
            err++; $display("FAIL small_start ready=%b hold=%b exp 1/1", LD_READY, HOLD); end
        for (int i = 0; i < 4; i++) begin
            LD_VALID = 1'b1; LD_DATA = b[i]; mmem[i] = b[i];
            step();
            LD_VALID = 1'b0;
            if (i < 3) begin
                vec++; if (LD_DONE !== 1'b0 || LD_READY !== 1'b1 || HOLD !== 1'b1) begin
                    err++; $display("FAIL small_mid byte=%0d done=%b ready=%b hold=%b exp 0/1/1", i, LD_DONE, LD_READY, HOLD); end
                if (i == int'(gap_at)) begin
                    step();
                    vec++; if (LD_DONE !== 1'b0 || LD_READY !== 1'b1) begin
                        err++; $display("FAIL small_gap done=%b ready=%b exp 0/1", LD_DONE, LD_READY); end
                end
            end else begin
                vec++; if (LD_DONE !== 1'b1 || HOLD !== 1'b0 || LD_READY !== 1'b0) begin
                    err++; $display("FAIL small_end done=%b hold=%b ready=%b exp 1/0/0", LD_DONE, HOLD, LD_READY); end
            end
        end
        step();
        vec++; if (LD_DONE !== 1'b0) begin err++; $display("FAIL small_done_drop got %b exp 0", LD_DONE); end
        for (int k = 0; k < 8; k++) begin
            p = (k < 4) ? 8'(k) : 8'($urandom_range(0, 3));
            PC = p;
            #1;
            vec++; if (INST !== mmem[p]) begin err++; $display("FAIL small_fetch pc=%h got %h exp %h", p, INST, mmem[p]); end
            step();
        end
    endtask

    task automatic test_debug_run;
        int unsigned n;
        logic [15:0] ref_acc, acc;
        logic [7:0]  ref_pc, p, a;
        int unsigned lat, holds;
        n = 12;
        ref_acc = '0; ref_pc = '0;
        for (int c = 0; c < 12; c++) begin
            ref_acc = ref_acc + 16'(mmem[ref_pc]);
            ref_pc  = (ref_pc + 8'd1) & 8'h03;
        end
        acc = '0; p = '0;
        DBG_ADDR = 8'h02;
        for (int c = 0; c <= int'(n); c++) begin
            PC = p;
            if (c == 1) DBG_REQ = 1'b1;
            #1;
            vec++; if (HOLD !== (c == int'(DBG_WAIT))) begin
                err++; $display("FAIL dbg_hold cyc=%0d got %b exp %b", c, HOLD, (c == int'(DBG_WAIT))); end
            vec++; if (DBG_ACK !== (c == int'(DBG_WAIT) + 1)) begin
                err++; $display("FAIL dbg_ack cyc=%0d got %b exp %b", c, DBG_ACK, (c == int'(DBG_WAIT) + 1)); end
            if (c == int'(DBG_WAIT) + 1) begin
                vec++; if (DBG_DATA !== mmem[2]) begin err++; $display("FAIL dbg_data got %h exp %h", DBG_DATA, mmem[2]); end
                DBG_REQ = 1'b0;
            end
            if (HOLD === 1'b0) begin
                acc = acc + 16'(INST);
                p   = (p + 8'd1) & 8'h03;
            end else begin
                vec++; if (INST !== 8'h00) begin err++; $display("FAIL dbg_inst_blank got %h exp 00", INST); end
            end
            step();
        end
        vec++; if (acc !== ref_acc || p !== ref_pc) begin
            err++; $display("FAIL dbg_trace acc=%h pc=%h exp %h/%h", acc, p, ref_acc, ref_pc); end
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) step();
            a = 8'($urandom_range(0, 3));
            DBG_ADDR = a; DBG_REQ = 1'b1;
            lat = 0; holds = 0;
            while (lat < 40) begin
                #1;
                if (HOLD === 1'b1) holds++;
                step();
                lat++;
                if (DBG_ACK === 1'b1) break;
            end
            DBG_REQ = 1'b0;
            vec++; if (lat !== DBG_WAIT || DBG_ACK !== 1'b1 || holds !== 1) begin
                err++; $display("FAIL dbg_rand_latency got %0d holds=%0d exp %0d holds=1", lat, holds, DBG_WAIT); end
            vec++; if (DBG_DATA !== mmem[a]) begin err++; $display("FAIL dbg_rand_data addr=%h got %h exp %h", a, DBG_DATA, mmem[a]); end
            step();
        end
    endtask

    task automatic test_go_ld_start;
        logic [7:0] d;
        go_idle();
        GO = 1'b1; LD_START = 1'b1; LD_LEN = 8'h03;
        step();
        GO = 1'b0; LD_START = 1'b0;
        vec++; if (LD_READY !== 1'b1 || HOLD !== 1'b1) begin
            err++; $display("FAIL both_start ready=%b hold=%b exp 1/1", LD_READY, HOLD); end
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            LD_VALID = 1'b1; LD_DATA = d; mmem[i] = d;
            LD_START = (i == 1); LD_LEN = (i == 1) ? 8'h00 : 8'h03;
            step();
            LD_VALID = 1'b0; LD_START = 1'b0;
            vec++; if (LD_DONE !== (i == 3)) begin
                err++; $display("FAIL ignore_start byte=%0d done=%b exp %b", i, LD_DONE, (i == 3)); end
        end
        for (int k = 0; k < 4; k++) begin
            PC = 8'(k);
            #1;
            vec++; if (INST !== mmem[k]) begin err++; $display("FAIL ignore_fetch pc=%0d got %h exp %h", k, INST, mmem[k]); end
            step();
        end
    endtask

    task automatic test_reset_midload;
        logic [7:0] d;
        LD_LEN = 8'h03; LD_START = 1'b1;
        step();
        LD_START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            LD_VALID = 1'b1; LD_DATA = d; mmem[i] = d;
            step();
            LD_VALID = 1'b0;
        end
        CLB = 1'b1;
        step();
        vec++; if (HOLD !== 1'b1 || LD_READY !== 1'b0 || LD_DONE !== 1'b0) begin
            err++; $display("FAIL midreset hold=%b ready=%b done=%b exp 1/0/0", HOLD, LD_READY, LD_DONE); end
        step();
        CLB = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            vec++; if (HOLD !== 1'b1 || LD_DONE !== 1'b0) begin
                err++; $display("FAIL midreset_idle hold=%b done=%b exp 1/0", HOLD, LD_DONE); end
        end
        for (int k = 0; k < 2; k++) begin
            DBG_ADDR = (k == 0) ? 8'h01 : 8'h03;
            DBG_REQ = 1'b1;
            step();
            vec++; if (DBG_ACK !== 1'b1 || DBG_DATA !== mmem[DBG_ADDR]) begin
                err++; $display("FAIL idle_dbg addr=%h ack=%b data=%h exp 1/%h", DBG_ADDR, DBG_ACK, DBG_DATA, mmem[DBG_ADDR]); end
            DBG_REQ = 1'b0;
            step();
            vec++; if (DBG_ACK !== 1'b0) begin err++; $display("FAIL idle_dbg_ack_drop got %b exp 0", DBG_ACK); end
        end
    endtask

    task automatic test_debug_cancel;
        logic [7:0] a;
        int unsigned lat;
        GO = 1'b1;
        step();
        GO = 1'b0;
        PC = 8'h00;
        a = 8'($urandom_range(0, 3));
        DBG_ADDR = a; DBG_REQ = 1'b1;
        repeat (DBG_WAIT - 1) begin
            #1;
            vec++; if (HOLD !== 1'b0) begin err++; $display("FAIL cancel_wait_hold got %b exp 0", HOLD); end
            step();
        end
        DBG_REQ = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            vec++; if (HOLD !== 1'b0 || DBG_ACK !== 1'b0) begin
                err++; $display("FAIL cancel_quiet hold=%b ack=%b exp 0/0", HOLD, DBG_ACK); end
            step();
        end
        DBG_REQ = 1'b1;
        lat = 0;
        while (lat < 40) begin
            step();
            lat++;
            if (DBG_ACK === 1'b1) break;
        end
        DBG_REQ = 1'b0;
        vec++; if (lat !== DBG_WAIT || DBG_DATA !== mmem[a]) begin
            err++; $display("FAIL cancel_rerequest lat=%0d data=%h exp %0d/%h", lat, DBG_DATA, DBG_WAIT, mmem[a]); end
        step();
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_load_small();
        test_debug_run();
        test_go_ld_start();
        test_reset_midload();
        test_debug_cancel();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
